// File: rtl/lutram_port_sched_if.sv
// Bus bundle between the port scheduler, its requesters and the dual-port LUT RAM.
interface lutram_port_sched_if #(
  parameter int DATA = 72,
  parameter int ADDR = 10
);
  // clear sweep control
  logic            clr_start;
  logic            clr_busy;
  logic            clr_done;
  // write requester 0
  logic            w0_valid;
  logic            w0_ready;
  logic [ADDR-1:0] w0_addr;
  logic [DATA-1:0] w0_data;
  // write requester 1
  logic            w1_valid;
  logic            w1_ready;
  logic [ADDR-1:0] w1_addr;
  logic [DATA-1:0] w1_data;
  // read requester and read return
  logic            r_valid;
  logic            r_ready;
  logic [ADDR-1:0] r_addr;
  logic            rd_valid;
  logic [DATA-1:0] rd_data;
  // RAM side: port A read, port B write
  logic [ADDR-1:0] ram_a_addr;
  logic [DATA-1:0] ram_a_dout;
  logic            ram_b_wr;
  logic [ADDR-1:0] ram_b_addr;
  logic [DATA-1:0] ram_b_din;

  modport slave (
    input  clr_start,
    output clr_busy, clr_done,
    input  w0_valid, w0_addr, w0_data,
    output w0_ready,
    input  w1_valid, w1_addr, w1_data,
    output w1_ready,
    input  r_valid, r_addr,
    output r_ready, rd_valid, rd_data,
    output ram_a_addr,
    input  ram_a_dout,
    output ram_b_wr, ram_b_addr, ram_b_din
  );

  modport master (
    output clr_start,
    input  clr_busy, clr_done,
    output w0_valid, w0_addr, w0_data,
    input  w0_ready,
    output w1_valid, w1_addr, w1_data,
    input  w1_ready,
    output r_valid, r_addr,
    input  r_ready, rd_valid, rd_data,
    input  ram_a_addr,
    output ram_a_dout,
    input  ram_b_wr, ram_b_addr, ram_b_din
  );
endinterface

// File: rtl/lutram_port_sched.sv
// Port scheduler for a dual-port LUT RAM: round-robin write arbitration onto
// port B, fixed-latency reads on port A with same-address collision stall,
// and a full-memory clear sweep.
module lutram_port_sched #(
  parameter int              DATA         = 72,
  parameter int              ADDR         = 10,
  parameter logic [DATA-1:0] CLR_VAL      = '0,
  parameter bit              CLR_ON_RESET = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  lutram_port_sched_if.slave  bus
);

  typedef enum logic {RUN, CLEAR} state_t;

  state_t          state, state_nxt;
  logic [ADDR-1:0] counter, counter_nxt;
  logic            rr_ptr, rr_ptr_nxt;     // 0: w0 wins a tie, 1: w1 wins a tie
  logic            rd_valid_q;
  logic            clr_done_q, clr_done_nxt;

  logic            gnt0, gnt1;
  logic            wr_en;
  logic [ADDR-1:0] wr_addr;
  logic [DATA-1:0] wr_data;
  logic [ADDR-1:0] rd_addr;
  logic            rd_ready;
  logic            w0_rdy, w1_rdy;

  // Next-state, arbitration and RAM port drive; the reset cycle issues no operation
  // so a sweep aborted by reset writes nothing further.
  always_comb begin
    state_nxt    = state;
    counter_nxt  = counter;
    rr_ptr_nxt   = rr_ptr;
    clr_done_nxt = 1'b0;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    rd_addr      = '0;
    rd_ready     = 1'b0;
    w0_rdy       = 1'b0;
    w1_rdy       = 1'b0;
    if (!reset) begin
      unique case (state)
        RUN: begin
          rd_addr = bus.r_addr;
          if (bus.clr_start) begin
            state_nxt   = CLEAR;
            counter_nxt = '0;
          end else begin
            gnt0 = bus.w0_valid && (!bus.w1_valid || !rr_ptr);
            gnt1 = bus.w1_valid && (!bus.w0_valid ||  rr_ptr);
            if (gnt0) begin
              w0_rdy     = 1'b1;
              wr_en      = 1'b1;
              wr_addr    = bus.w0_addr;
              wr_data    = bus.w0_data;
              rr_ptr_nxt = 1'b1;
            end else if (gnt1) begin
              w1_rdy     = 1'b1;
              wr_en      = 1'b1;
              wr_addr    = bus.w1_addr;
              wr_data    = bus.w1_data;
              rr_ptr_nxt = 1'b0;
            end
            // A read of the location being written this cycle would see the old
            // word, so stall it one cycle to return the new one.
            rd_ready = bus.r_valid && !(wr_en && (wr_addr == bus.r_addr));
          end
        end
        CLEAR: begin
          wr_en       = 1'b1;
          wr_addr     = counter;
          wr_data     = CLR_VAL;
          counter_nxt = counter + ADDR'(1);
          if (counter == '1) begin
            state_nxt    = RUN;
            clr_done_nxt = 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // State, sweep counter, round-robin pointer and read-return register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLR_ON_RESET ? CLEAR : RUN;
      counter    <= '0;
      rr_ptr     <= 1'b0;
      rd_valid_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      counter    <= counter_nxt;
      rr_ptr     <= rr_ptr_nxt;
      rd_valid_q <= rd_ready;
      clr_done_q <= clr_done_nxt;
    end
  end

  assign bus.w0_ready   = w0_rdy;
  assign bus.w1_ready   = w1_rdy;
  assign bus.r_ready    = rd_ready;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = bus.ram_a_dout;
  assign bus.ram_a_addr = rd_addr;
  assign bus.ram_b_wr   = wr_en;
  assign bus.ram_b_addr = wr_addr;
  assign bus.ram_b_din  = wr_data;
  assign bus.clr_busy   = (state == CLEAR);
  assign bus.clr_done   = clr_done_q;

endmodule

// File: tb/tb_lutram_port_sched.sv
// Directed bench for lutram_port_sched with a read-first RAM model on the ports.
module tb_lutram_port_sched;
  localparam int DATA = 8;
  localparam int ADDR = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  lutram_port_sched_if #(.DATA(DATA), .ADDR(ADDR)) bus  ();
  lutram_port_sched_if #(.DATA(DATA), .ADDR(ADDR)) bus2 ();

  lutram_port_sched #(.DATA(DATA), .ADDR(ADDR), .CLR_VAL(8'h00), .CLR_ON_RESET(1'b0)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  lutram_port_sched #(.DATA(DATA), .ADDR(ADDR), .CLR_VAL(8'h00), .CLR_ON_RESET(1'b1)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  // Dual-port RAM model: registered read-first port A, write port B.
  logic [DATA-1:0] mem [16];
  always @(posedge clk) begin
    if (bus.ram_b_wr) mem[bus.ram_b_addr] <= bus.ram_b_din;
    bus.ram_a_dout <= mem[bus.ram_a_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.clr_start = 0; bus.w0_valid = 0; bus.w0_addr = '0; bus.w0_data = '0;
    bus.w1_valid = 0; bus.w1_addr = '0; bus.w1_data = '0;
    bus.r_valid = 0; bus.r_addr = '0;
    bus2.clr_start = 0; bus2.w0_valid = 0; bus2.w0_addr = '0; bus2.w0_data = '0;
    bus2.w1_valid = 0; bus2.w1_addr = '0; bus2.w1_data = '0;
    bus2.r_valid = 0; bus2.r_addr = '0; bus2.ram_a_dout = '0;
    tick(); tick();

    // reset state
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_clr_busy", bus.clr_busy, 0);
    chk("rst_clr_done", bus.clr_done, 0);
    chk("rst_ram_b_wr", bus.ram_b_wr, 0);
    chk("rst2_clr_busy", bus2.clr_busy, 1);

    // CLR_ON_RESET instance sweeps 16 cycles after reset release
    reset = 1'b0;
    for (int unsigned i = 0; i < 15; i++) tick();
    chk("cor_busy_15", bus2.clr_busy, 1);
    chk("cor_done_15", bus2.clr_done, 0);
    tick();
    chk("cor_busy_16", bus2.clr_busy, 0);
    chk("cor_done_16", bus2.clr_done, 1);
    tick();
    chk("cor_done_17", bus2.clr_done, 0);

    // round robin from reset pointer: w0,w1,w0,w1
    bus.w0_valid = 1; bus.w0_addr = 4'd1; bus.w0_data = 8'h11;
    bus.w1_valid = 1; bus.w1_addr = 4'd2; bus.w1_data = 8'h22;
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      chk("rr_w0_ready", bus.w0_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_w1_ready", bus.w1_ready, (i % 2 == 0) ? 0 : 1);
      chk("rr_b_addr",   bus.ram_b_addr, (i % 2 == 0) ? 1 : 2);
      tick();
    end
    bus.w0_valid = 0; bus.w1_valid = 0;

    // write then read back
    bus.w0_valid = 1; bus.w0_addr = 4'd3; bus.w0_data = 8'hAA;
    #1;
    chk("wr_w0_ready", bus.w0_ready, 1);
    chk("wr_b_wr", bus.ram_b_wr, 1);
    chk("wr_b_din", bus.ram_b_din, 8'hAA);
    tick();
    bus.w0_valid = 0;
    bus.r_valid = 1; bus.r_addr = 4'd3;
    #1;
    chk("rd_ready", bus.r_ready, 1);
    tick();
    bus.r_valid = 0;
    chk("rd_valid", bus.rd_valid, 1);
    chk("rd_data_3", bus.rd_data, 8'hAA);
    tick();
    chk("rd_valid_drop", bus.rd_valid, 0);
    chk("idle_b_wr", bus.ram_b_wr, 0);

    // same-address collision stalls the read one cycle
    bus.w1_valid = 1; bus.w1_addr = 4'd5; bus.w1_data = 8'h3C;
    bus.r_valid = 1; bus.r_addr = 4'd5;
    #1;
    chk("col_w1_ready", bus.w1_ready, 1);
    chk("col_r_ready", bus.r_ready, 0);
    tick();
    bus.w1_valid = 0;
    chk("col_no_rd_valid", bus.rd_valid, 0);
    #1;
    chk("col_retry_ready", bus.r_ready, 1);
    tick();
    bus.r_valid = 0;
    chk("col_rd_valid", bus.rd_valid, 1);
    chk("col_rd_data", bus.rd_data, 8'h3C);

    // different addresses proceed together
    bus.w0_valid = 1; bus.w0_addr = 4'd6; bus.w0_data = 8'h66;
    bus.r_valid = 1; bus.r_addr = 4'd1;
    #1;
    chk("par_w0_ready", bus.w0_ready, 1);
    chk("par_r_ready", bus.r_ready, 1);
    tick();
    bus.w0_valid = 0; bus.r_valid = 0;
    chk("par_rd_data", bus.rd_data, 8'h11);

    // clear sweep; clr_start beats requests, mid-sweep clr_start ignored
    bus.clr_start = 1;
    bus.w0_valid = 1; bus.r_valid = 1; bus.r_addr = 4'd2;
    #1;
    chk("cs_w0_ready", bus.w0_ready, 0);
    chk("cs_r_ready", bus.r_ready, 0);
    chk("cs_b_wr", bus.ram_b_wr, 0);
    tick();
    bus.clr_start = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      bus.clr_start = (i == 7);
      #1;
      chk("clr_busy", bus.clr_busy, 1);
      chk("clr_b_addr", bus.ram_b_addr, i);
      if (i == 0 || i == 15) begin
        chk("clr_b_wr", bus.ram_b_wr, 1);
        chk("clr_w0_ready", bus.w0_ready, 0);
        chk("clr_r_ready", bus.r_ready, 0);
      end
      if (i == 15) begin
        bus.w0_valid = 0; bus.r_valid = 0;
      end
      tick();
    end
    bus.clr_start = 0;
    chk("clr_end_busy", bus.clr_busy, 0);
    chk("clr_end_done", bus.clr_done, 1);
    tick();
    chk("clr_done_pulse", bus.clr_done, 0);
    for (int unsigned a = 0; a < 16; a++) begin
      bus.r_valid = 1; bus.r_addr = ADDR'(a);
      tick();
      chk("clr_read", bus.rd_data, 8'h00);
    end
    bus.r_valid = 0;

    // refill, then reset at sweep counter 8
    for (int unsigned a = 0; a < 16; a++) begin
      bus.w0_valid = 1; bus.w0_addr = ADDR'(a); bus.w0_data = DATA'(8'hA0 + a);
      tick();
    end
    bus.w0_valid = 0;
    bus.clr_start = 1;
    tick();
    bus.clr_start = 0;
    for (int unsigned i = 0; i < 8; i++) tick();
    reset = 1'b1;
    #1;
    chk("abort_b_wr", bus.ram_b_wr, 0);
    tick();
    reset = 1'b0;
    chk("abort_busy", bus.clr_busy, 0);
    for (int unsigned a = 0; a < 16; a++) begin
      bus.r_valid = 1; bus.r_addr = ADDR'(a);
      tick();
      chk("abort_read", bus.rd_data, (a < 8) ? 8'h00 : 8'hA0 + a);
    end
    bus.r_valid = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
